pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Each cycle it generates per-latch enable and flush controls from four inputs: memory-wait status, load-use hazards, taken branches/jumps, and halt.
- Holds a small state machine that tracks outstanding data accesses, remembers early instruction hits, and latches halt.
- Sits beside the datapath; all pipeline latch interfaces take their _en/_flush from this block.

Parameters:
REGW, 5, register-address width of rs/rt/wsel compares
CNT_W, 32, width of performance counters (only with PIPE_PERF_EN)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
ihit  in  1  instruction fetch for current PC complete (pulse)
dhit  in  1  data access of MEM-stage instruction complete (pulse)
exmem_dmemREN  in  1  MEM-stage instruction is a load
exmem_dmemWEN  in  1  MEM-stage instruction is a store
exmem_hlt  in  1  MEM-stage instruction is halt
idex_dmemREN  in  1  EX-stage instruction is a load
idex_wsel  in  REGW  EX-stage destination register
ifid_rs  in  REGW  decode-stage source rs
ifid_rt  in  REGW  decode-stage source rt
branch_taken  in  1  EX-stage branch/jump redirects PC this cycle
pc_en  out  1  PC update enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch update enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (all zero) instead of data when enabled
imemREN  out  1  instruction read request
halt  out  1  processor halted, sticky
state  out  2  FSM state: 0 RUN, 1 MEMWAIT, 2 HALTED

Behaviour:
- Reset (async, RST=1):
  - state=RUN, ihit_seen=0.
  - All outputs 0 except imemREN=1.
- Internal signals:
  - memop = exmem_dmemREN|exmem_dmemWEN.
  - freeze = memop & ~dhit.
  - fetch_ok = ihit | ihit_seen.
  - lu = idex_dmemREN & (idex_wsel!=0) & (idex_wsel==ifid_rs | idex_wsel==ifid_rt).
- Outputs are combinational from state and inputs. Priority in RUN/MEMWAIT, highest first:
  1. freeze:
     - pc_en=ifid_en=idex_en=exmem_en=0.
     - memwb_en=1, memwb_flush=1.
  2. exmem_hlt (RUN only):
     - memwb_en=1, all other enables 0.
     - Next state HALTED.
  3. branch_taken:
     - All enables 1, pc_en=1.
     - ifid_flush=1, idex_flush=1.
     - Overrides lu and !fetch_ok.
  4. lu:
     - pc_en=0, ifid_en=0.
     - idex_en=1, idex_flush=1.
     - exmem_en=memwb_en=1.
  5. !fetch_ok:
     - pc_en=0.
     - ifid_en=1, ifid_flush=1.
     - Downstream latches enabled.
  6. Otherwise: all enables 1, no flush.
- lu and !fetch_ok together: lu outputs apply, and PC holds in both cases.
- ihit_seen register:
  - Set on ihit while pc_en=0.
  - Cleared on any cycle with pc_en=1.
  - ihit during a freeze is never lost.
- FSM:
  - RUN→MEMWAIT when freeze.
  - RUN→HALTED on exmem_hlt & ~freeze.
  - MEMWAIT→RUN on dhit; the pipeline advances in that same cycle.
  - HALTED is absorbing until RST.
  - dhit coincident with memop in RUN: no wait state, zero added latency.
- HALTED: all enables 0, flushes 0, imemREN=0, halt=1.
- imemREN=1 in RUN and MEMWAIT.
- dhit with memop=0 is ignored.
- RST asserted mid-MEMWAIT aborts to RUN immediately; the outstanding access is discarded.

Optional Feature:
- Macro: PIPE_PERF_EN.
- When defined, adds output ports:
  - stall_cnt [CNT_W]: increments each non-HALTED cycle with pc_en=0.
  - flush_cnt [CNT_W]: increments each cycle with branch_taken & ~freeze.
- Both counters reset to 0, saturate at all-ones, and freeze in HALTED.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Load in MEM (exmem_dmemREN=1), dhit low 3 cycles then high:
  - state=1 for 3 cycles, pc_en=0, memwb_flush=1.
  - 4th cycle state→0 and all enables=1.
- idex_dmemREN=1, idex_wsel=5, ifid_rt=5, ihit=1:
  - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1.
  - Repeat with idex_wsel=0: no stall.
- branch_taken=1 concurrent with lu=1:
  - pc_en=1, ifid_flush=1, idex_flush=1, no hold.
- ihit pulse during freeze, then dhit:
  - On release, pc_en=1 without a new ihit.
  - ihit_seen cleared the next cycle.
- exmem_hlt=1, memop=0:
  - That cycle memwb_en=1, others 0.
  - Next cycle halt=1, state=2, imemREN=0; halt stays 1 despite further inputs.
- RST pulse while state=1:
  - state=0 and imemREN=1 asynchronously.
  - With PIPE_PERF_EN, counters=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-latch enable/flush sequencer for the 5-stage pipeline.
// Optional PIPE_PERF_EN adds saturating stall/flush counters.
module pipeline_ctrl #(
  parameter int REGW = 5
`ifdef PIPE_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            exmem_dmemREN,
  input  logic            exmem_dmemWEN,
  input  logic            exmem_hlt,
  input  logic            idex_dmemREN,
  input  logic [REGW-1:0] idex_wsel,
  input  logic [REGW-1:0] ifid_rs,
  input  logic [REGW-1:0] ifid_rt,
  input  logic            branch_taken,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            memwb_flush,
  output logic            imemREN,
  output logic            halt,
  output logic [1:0]      state
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MEMWAIT = 2'd1,
    S_HALTED  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_ihit_seen;

  logic w_memop;
  logic w_freeze;
  logic w_fetch_ok;
  logic w_lu;

  assign w_memop    = exmem_dmemREN | exmem_dmemWEN;
  assign w_freeze   = w_memop & ~dhit;
  assign w_fetch_ok = ihit | r_ihit_seen;
  assign w_lu       = idex_dmemREN
                    & (idex_wsel != '0)
                    & ((idex_wsel == ifid_rs)
                     | (idex_wsel == ifid_rt));

  assign state = r_state;

  // State register; reset aborts any outstanding data access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  // Remember a fetch that completed while the PC was held.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       r_ihit_seen <= 1'b0;
    else if (pc_en) r_ihit_seen <= 1'b0;
    else if (ihit)  r_ihit_seen <= 1'b1;
  end

  // Next state and latch controls, highest-priority condition first.
  always_comb begin
    w_next      = r_state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    imemREN     = 1'b0;
    halt        = 1'b0;
    if (RST) begin
      imemREN = 1'b1;
    end else begin
      unique case (r_state)
        S_RUN, S_MEMWAIT: begin
          imemREN = 1'b1;
          if (w_freeze) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
            w_next      = S_MEMWAIT;
          end else if (exmem_hlt && r_state == S_RUN) begin
            memwb_en = 1'b1;
            w_next   = S_HALTED;
          end else begin
            w_next   = S_RUN;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (branch_taken) begin
              pc_en      = 1'b1;
              ifid_en    = 1'b1;
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (w_lu) begin
              idex_flush = 1'b1;
            end else if (!w_fetch_ok) begin
              ifid_en    = 1'b1;
              ifid_flush = 1'b1;
            end else begin
              pc_en   = 1'b1;
              ifid_en = 1'b1;
            end
          end
        end
        S_HALTED: begin
          halt = 1'b1;
        end
        default: begin
          w_next = S_RUN;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_EN
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_stall_inc = (r_state != S_HALTED) & ~pc_en;
  assign w_flush_inc = (r_state != S_HALTED)
                     & branch_taken & ~w_freeze;

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Saturating stall counter, frozen once halted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_stall_cnt <= '0;
    else if (w_stall_inc && r_stall_cnt != '1)
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  // Saturating redirect-flush counter, frozen once halted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_flush_cnt <= '0;
    else if (w_flush_inc && r_flush_cnt != '1)
      r_flush_cnt <= r_flush_cnt + CNT_W'(1);
  end
`endif

endmodule
